pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives load enables and clears of PC,
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers from load-use hazards, taken branches and data-memory
//  wait handshakes. Sits in the top-level core beside the hazard inputs from ID/EX/MEM stages.
// PARAMETERS
//  REG_AW      5   register-index width
//  LU_BUBBLES  1   bubbles inserted per load-use hazard (1..3)
//  CNT_W       32  perf counter width (HAZARD_PERF_EN only)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  id_rs1/id_rs2  in   REG_AW  source regs of instruction in ID
//  id_use_rs1/2   in   1       ID instruction actually reads rs1/rs2
//  ex_rd          in   REG_AW  destination reg of instruction in EX
//  ex_mem_read    in   1       EX instruction is a load
//  branch_taken   in   1       EX resolved taken branch/jump (PC target valid)
//  dmem_req       in   1       MEM stage issuing data-memory access
//  dmem_ready     in   1       data memory completes access this cycle
//  pc_we          out  1       PC load enable
//  ifid_en        out  1       IF/ID load enable (1=load, 0=hold)
//  ifid_clr       out  1       IF/ID synchronous clear
//  idex_en/idex_clr   out 1    ID/EX load enable / clear (clear wins)
//  exmem_en       out  1       EX/MEM load enable
//  memwb_clr      out  1       MEM/WB clear (bubble)
// BEHAVIOUR
//  - Outputs combinational from state + inputs, zero latency. While rst=1: pc_we=ifid_en=idex_en=
//    exmem_en=0, ifid_clr=idex_clr=memwb_clr=1; state=RUN, lu_cnt=0, ret_st=RUN, pend_flush=0.
//  - lu_hit = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - Default (RUN, no event): all *_en=1, all *_clr=0.
//  - Priority per cycle: mem wait > branch flush > load-use.
//  - mem_wait = dmem_req & !dmem_ready. Freeze: pc_we=ifid_en=idex_en=exmem_en=0, memwb_clr=1.
//    Entering from RUN/LU_STALL: ret_st<=current state, state<=MEM_WAIT. req&ready same cycle = no wait.
//  - Flush (branch_taken, not mem_wait): pc_we=1, ifid_clr=1, idex_clr=1; lu_cnt<=0, state<=RUN.
//  - Load-use in RUN: pc_we=0, ifid_en=0, idex_clr=1; if LU_BUBBLES>1 lu_cnt<=LU_BUBBLES-1, ->LU_STALL.
//  - LU_STALL: same outputs as load-use; lu_cnt decrements; lu_cnt==1 -> RUN.
//  - MEM_WAIT: freeze outputs; branch_taken sampled -> pend_flush<=1. On dmem_ready: if
//    pend_flush|branch_taken apply flush outputs, clear pend_flush, ->RUN; else ->ret_st (lu_cnt kept).
//  - rst mid-wait/mid-stall: immediate async return to reset state; pending flush discarded.
// CONFIGURATION
//  HAZARD_PERF_EN defined: ports perf_lu, perf_mem, perf_flush (out, CNT_W) count load-use bubble
//   cycles, MEM_WAIT cycles, flush events; saturate at all-ones; cleared by rst.
//  Undefined: ports and counters absent; control behaviour identical.
// STRUCTURE
//  - hazard_ctrl_pkg: state encodings RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2; REG_AW default.
//  - Sub-module hazard_lu_cmp: combinational lu_hit comparator (reused by forwarding unit).
//  - Top holds state, ret_st, lu_cnt, pend_flush, optional counters, output decode.
// TESTING
//  1 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, LU_BUBBLES=1 -> one cycle pc_we=0, ifid_en=0,
//    idex_clr=1; next cycle all enables 1.
//  2 same hazard with ex_rd=0 or id_use_rs2=0 -> no stall.
//  3 LU_BUBBLES=3, hazard -> 3 consecutive stall cycles then RUN; perf_lu=3 with HAZARD_PERF_EN.
//  4 dmem_req=1, dmem_ready=0 for 4 cycles -> 4 frozen cycles, memwb_clr=1; ready cycle enables=1.
//  5 branch_taken+hazard same cycle -> flush only (pc_we=1, ifid_clr=idex_clr=1); branch during
//    MEM_WAIT -> flush applied on the dmem_ready cycle.
//  6 rst pulse during MEM_WAIT -> reset outputs immediately; after release RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_lu_cmp.sv
// Load-use hazard comparator: EX holds a load whose rd is a live source of the ID instruction.
// Latency: purely combinational.
// Backpressure: none; it only reports the hazard.
module hazard_lu_cmp #(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu_hit
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        lu_hit = ex_mem_read && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer driving PC and pipeline-register enables/clears for a 5-stage pipeline.
// Latency: outputs are combinational from state and inputs (zero cycles).
// Backpressure: a data-memory wait freezes the whole pipe; a branch taken during the wait is held and applied on completion.
// Option HAZARD_PERF_EN adds saturating perf counters perf_lu / perf_mem / perf_flush.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              ifid_en,
    output logic              ifid_clr,
    output logic              idex_en,
    output logic              idex_clr,
    output logic              exmem_en,
    output logic              memwb_clr
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_lu,
    output logic [CNT_W-1:0]  perf_mem,
    output logic [CNT_W-1:0]  perf_flush
`endif
);

    hz_state_t  state, state_nxt, ret_st, ret_nxt;
    logic [1:0] lu_cnt, cnt_nxt;
    logic       pend_flush, pend_nxt;
    logic       lu_hit, mem_wait;
    logic       ev_lu, ev_mem, ev_flush;

    hazard_lu_cmp #(.REG_AW(REG_AW)) u_lu_cmp (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hit      (lu_hit)
    );

    assign mem_wait = dmem_req && !dmem_ready;

    // Next-state and output decode; priority is mem wait, then branch flush, then load-use.
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_st;
        cnt_nxt   = lu_cnt;
        pend_nxt  = pend_flush;
        ev_lu     = 1'b0;
        ev_mem    = 1'b0;
        ev_flush  = 1'b0;
        pc_we     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_en   = 1'b1;
        idex_clr  = 1'b0;
        exmem_en  = 1'b1;
        memwb_clr = 1'b0;

        case (state)
            MEM_WAIT: begin
                if (dmem_ready) begin
                    if (pend_flush || branch_taken) begin
                        ev_flush  = 1'b1;
                        pend_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end else begin
                        // Resume where the wait interrupted; any remaining stall count is kept.
                        state_nxt = ret_st;
                    end
                end else begin
                    ev_mem = 1'b1;
                    if (branch_taken) pend_nxt = 1'b1;
                end
            end
            default: begin
                if (mem_wait) begin
                    ev_mem    = 1'b1;
                    ret_nxt   = state;
                    state_nxt = MEM_WAIT;
                end else if (branch_taken) begin
                    ev_flush  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end else if (state == LU_STALL) begin
                    ev_lu   = 1'b1;
                    cnt_nxt = lu_cnt - 2'd1;
                    if (lu_cnt == 2'd1) state_nxt = RUN;
                end else if (lu_hit) begin
                    ev_lu = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        cnt_nxt   = 2'(LU_BUBBLES - 1);
                        state_nxt = LU_STALL;
                    end
                end
            end
        endcase

        if (ev_mem) begin
            pc_we     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
        end else if (ev_flush) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (ev_lu) begin
            pc_we    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end

        // Reset forces a safe, fully bubbled pipe regardless of the clock.
        if (rst) begin
            pc_we     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            memwb_clr = 1'b1;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            ret_st     <= RUN;
            lu_cnt     <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            ret_st     <= ret_nxt;
            lu_cnt     <= cnt_nxt;
            pend_flush <= pend_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters: bubble cycles, frozen cycles, flush events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu    <= '0;
            perf_mem   <= '0;
            perf_flush <= '0;
        end else begin
            if (ev_lu && (perf_lu != '1))       perf_lu    <= perf_lu + 1'b1;
            if (ev_mem && (perf_mem != '1))     perf_mem   <= perf_mem + 1'b1;
            if (ev_flush && (perf_flush != '1)) perf_flush <= perf_flush + 1'b1;
        end
    end
`endif

endmodule
